// File: rtl/axi_lite_if.sv
// AXI4-Lite signal bundle shared by the LSU master and the slave side of the crossbar.
// Every channel uses valid/ready: a raised valid holds, with stable payload, until ready is seen.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_lite_lsu_master.sv
// Single-outstanding LSU request to AXI4-Lite initiator: lane steering for stores,
// right-align and extend for loads, local rejection of misaligned or size-3 accesses.
module axi_lite_lsu_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [2:0]        dbg_state,
  axi_lite_if.master        m
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    WR_AWW = 3'd3,
    WR_B   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        strb_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              aw_done, w_done;

  logic              misaligned;
  logic [3:0]        req_strb;
  logic [DATA_W-1:0] rshift, rext;
  logic              aw_fin, w_fin;

  assign dbg_state = state;

  always_comb begin
    misaligned = 1'b0;
    req_strb   = 4'b1111;
    case (req_size)
      2'd0: req_strb = 4'b0001 << req_addr[1:0];
      2'd1: begin
        req_strb   = 4'b0011 << req_addr[1:0];
        misaligned = req_addr[0];
      end
      2'd2: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Read data arrives on its natural byte lanes; bring the addressed bytes down to bit 0.
  always_comb begin
    rshift = m.rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0: rext = uns_q ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      2'd1: rext = uns_q ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: rext = rshift;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    aw_fin     = aw_done | m.awready;
    w_fin      = w_done | m.wready;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    m.awvalid  = 1'b0;
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)   state_next = RESP;
          else if (req_wen) state_next = WR_AWW;
          else              state_next = RD_AR;
        end
      end
      RD_AR: begin
        m.arvalid = 1'b1;
        if (m.arready) state_next = RD_R;
      end
      RD_R: begin
        m.rready = 1'b1;
        if (m.rvalid) state_next = RESP;
      end
      WR_AWW: begin
        // AW and W retire independently; each valid drops once its own handshake is done.
        m.awvalid = ~aw_done;
        m.wvalid  = ~w_done;
        if (aw_fin && w_fin) state_next = WR_B;
      end
      WR_B: begin
        m.bready = 1'b1;
        if (m.bvalid) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign m.araddr = addr_q;
  assign m.awaddr = addr_q;
  assign m.wdata  = wdata_q;
  assign m.wstrb  = strb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata << {req_addr[1:0], 3'b000};
            strb_q  <= req_strb;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            if (misaligned) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        RD_R: begin
          if (m.rvalid) begin
            resp_err   <= (m.rresp != 2'b00);
            resp_rdata <= (m.rresp != 2'b00) ? '0 : rext;
          end
        end
        WR_AWW: begin
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (m.awready) aw_done <= 1'b1;
            if (m.wready)  w_done  <= 1'b1;
          end
        end
        WR_B: begin
          if (m.bvalid) begin
            resp_err   <= (m.bresp != 2'b00);
            resp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_lsu_master.sv
// Directed bench for axi_lite_lsu_master: a vector table run against an eager slave,
// plus hand sequences for split AW/W handshakes, response back-pressure and mid-read reset.
module tb_axi_lite_lsu_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_lsu_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dbg_state    (dbg_state),
    .m            (bus)
  );

  typedef struct {
    string       name;
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic        exp_bus;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    @(negedge clk);
    req_wen      = wen;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    bus.rvalid = 1'b0;
    bus.bvalid = 1'b0;
    check("resp_valid_drop", {31'b0, resp_valid}, 32'd0);
    check("req_ready_back", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    bit done, any_bus, ar_hs, aw_hs, w_hs;
    bus.arready = 1'b1;
    bus.awready = 1'b1;
    bus.wready  = 1'b1;
    bus.rdata   = v.s_rdata;
    bus.rresp   = v.s_resp;
    bus.bresp   = v.s_resp;
    issue(v.wen, v.addr, v.size, v.uns, v.wdata);
    n = 1; done = 0; any_bus = 0; ar_hs = 0; aw_hs = 0; w_hs = 0;
    while (!done && n <= 20) begin
      @(negedge clk);
      bus.rvalid = ar_hs;
      bus.bvalid = aw_hs && w_hs;
      if (bus.arvalid || bus.awvalid || bus.wvalid) any_bus = 1;
      if (bus.arvalid) begin
        check({v.name, ".araddr"}, bus.araddr, v.addr);
        ar_hs = bus.arready;
      end
      if (bus.awvalid) begin
        check({v.name, ".awaddr"}, bus.awaddr, v.addr);
        aw_hs = 1;
      end
      if (bus.wvalid) begin
        check({v.name, ".wdata"}, bus.wdata, v.exp_wdata);
        check({v.name, ".wstrb"}, {28'b0, bus.wstrb}, {28'b0, v.exp_wstrb});
        w_hs = 1;
      end
      if (resp_valid) done = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check({v.name, ".no_timeout"}, {31'b0, done}, 32'd1);
    check({v.name, ".latency"}, n, v.exp_lat);
    check({v.name, ".bus_used"}, {31'b0, any_bus}, {31'b0, v.exp_bus});
    check({v.name, ".rdata"}, resp_rdata, v.exp_rdata);
    check({v.name, ".err"}, {31'b0, resp_err}, {31'b0, v.exp_err});
    check({v.name, ".req_ready_busy"}, {31'b0, req_ready}, 32'd0);
    release_resp();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1;
    req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_unsigned = 0; req_wdata = 0;
    resp_ready = 0;
    bus.arready = 0; bus.rdata = 0; bus.rresp = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0;

    //       name       wen addr          sz uns wdata         s_rdata       resp   bus wdata exp     strb     rdata exp     err lat
    vecs.push_back('{"ld_word",  0, 32'ha0000048, 2, 0, 32'h0,        32'h12345678, 2'b00, 1, 32'h0,        4'hf,    32'h12345678, 0, 3});
    vecs.push_back('{"ld_sb",    0, 32'h80000003, 0, 0, 32'h0,        32'h80ffffff, 2'b00, 1, 32'h0,        4'h8,    32'hffffff80, 0, 3});
    vecs.push_back('{"ld_ub",    0, 32'h80000003, 0, 1, 32'h0,        32'h80ffffff, 2'b00, 1, 32'h0,        4'h8,    32'h00000080, 0, 3});
    vecs.push_back('{"ld_sh",    0, 32'h80000002, 1, 0, 32'h0,        32'h9abc1234, 2'b00, 1, 32'h0,        4'hc,    32'hffff9abc, 0, 3});
    vecs.push_back('{"ld_uh",    0, 32'h00000010, 1, 1, 32'h0,        32'h00008001, 2'b00, 1, 32'h0,        4'h3,    32'h00008001, 0, 3});
    vecs.push_back('{"ld_sb1",   0, 32'h00000001, 0, 0, 32'h0,        32'h00007f00, 2'b00, 1, 32'h0,        4'h2,    32'h0000007f, 0, 3});
    vecs.push_back('{"ld_slverr",0, 32'h00000100, 2, 0, 32'h0,        32'hdeadbeef, 2'b10, 1, 32'h0,        4'hf,    32'h00000000, 1, 3});
    vecs.push_back('{"st_b1",    1, 32'h00000081, 0, 0, 32'h000000ab, 32'h0,        2'b00, 1, 32'h0000ab00, 4'b0010, 32'h00000000, 0, 3});
    vecs.push_back('{"st_word",  1, 32'h00000200, 2, 0, 32'hcafef00d, 32'h0,        2'b00, 1, 32'hcafef00d, 4'b1111, 32'h00000000, 0, 3});
    vecs.push_back('{"st_slverr",1, 32'h00000204, 2, 0, 32'h11223344, 32'h0,        2'b10, 1, 32'h11223344, 4'b1111, 32'h00000000, 1, 3});
    vecs.push_back('{"mis_ldw",  0, 32'h80000002, 2, 0, 32'h0,        32'h0,        2'b00, 0, 32'h0,        4'h0,    32'h00000000, 1, 1});
    vecs.push_back('{"mis_sz3",  0, 32'h00000000, 3, 0, 32'h0,        32'h0,        2'b00, 0, 32'h0,        4'h0,    32'h00000000, 1, 1});
    vecs.push_back('{"mis_sth",  1, 32'h00000003, 1, 0, 32'h1234,     32'h0,        2'b00, 0, 32'h0,        4'h0,    32'h00000000, 1, 1});

    @(negedge clk);
    check("rst.req_ready", {31'b0, req_ready}, 32'd1);
    check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst.resp_err", {31'b0, resp_err}, 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.valids", {27'b0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 32'd0);
    check("rst.state", {29'b0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Store half: W accepted two cycles before AW.
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.rvalid = 0;
    issue(1'b1, 32'h80000002, 2'd1, 1'b0, 32'h0000beef);
    @(negedge clk);
    check("sth.awvalid0", {31'b0, bus.awvalid}, 32'd1);
    check("sth.wvalid0", {31'b0, bus.wvalid}, 32'd1);
    check("sth.awaddr", bus.awaddr, 32'h80000002);
    check("sth.wdata", bus.wdata, 32'hbeef0000);
    check("sth.wstrb", {28'b0, bus.wstrb}, 32'hc);
    bus.wready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.wready = 0;
    check("sth.wvalid_drop", {31'b0, bus.wvalid}, 32'd0);
    check("sth.awvalid_hold1", {31'b0, bus.awvalid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("sth.awvalid_hold2", {31'b0, bus.awvalid}, 32'd1);
    check("sth.bready_low", {31'b0, bus.bready}, 32'd0);
    bus.awready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.awready = 0;
    check("sth.awvalid_drop", {31'b0, bus.awvalid}, 32'd0);
    check("sth.bready", {31'b0, bus.bready}, 32'd1);
    bus.bresp = 2'b00;
    bus.bvalid = 1;
    @(posedge clk);
    @(negedge clk);
    bus.bvalid = 0;
    check("sth.resp_valid", {31'b0, resp_valid}, 32'd1);
    check("sth.err", {31'b0, resp_err}, 32'd0);
    check("sth.rdata", resp_rdata, 32'd0);
    release_resp();

    // Response held off for five cycles: outputs stay put, no new request taken.
    bus.arready = 1; bus.rdata = 32'h0badf00d; bus.rresp = 2'b00;
    issue(1'b0, 32'h00000060, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.rvalid = 1;
    @(posedge clk);
    @(negedge clk);
    bus.rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("bp.resp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp.rdata", resp_rdata, 32'h0badf00d);
      check("bp.req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    release_resp();

    // Asynchronous reset while waiting in the read-data state.
    bus.arready = 1; bus.rvalid = 0;
    issue(1'b0, 32'h00000044, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    check("rr.arvalid", {31'b0, bus.arvalid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rr.rready", {31'b0, bus.rready}, 32'd1);
    check("rr.state_rd_r", {29'b0, dbg_state}, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("rr.arvalid_rst", {31'b0, bus.arvalid}, 32'd0);
    check("rr.rready_rst", {31'b0, bus.rready}, 32'd0);
    check("rr.resp_valid_rst", {31'b0, resp_valid}, 32'd0);
    check("rr.state_rst", {29'b0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rr.req_ready_after", {31'b0, req_ready}, 32'd1);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
